// File: rtl/axi4_pkg.sv
// Shared AXI4 types and helpers for the core-side read/write arbiters.
// The 13-bit AXI ID carries a 3-bit channel field in its MSBs. The arbiters
// use that field to route responses back to the requester that issued them.
package axi4_pkg;

    localparam int AXI4_ID_W  = 13;
    localparam int AXI4_CH_W  = 3;
    localparam int AXI4_TAG_W = AXI4_ID_W - AXI4_CH_W;

    typedef struct packed {
        logic [AXI4_CH_W-1:0]  channel;
        logic [AXI4_TAG_W-1:0] tag;
    } axi4_id_t;

    typedef logic [2:0] axi4_size_t;

    typedef enum logic [1:0] {
        AXI4_BURST_FIXED = 2'b00,
        AXI4_BURST_INCR  = 2'b01,
        AXI4_BURST_WRAP  = 2'b10,
        AXI4_BURST_RSVD  = 2'b11
    } axi4_burst_t;

    typedef enum logic [1:0] {
        AXI4_RESP_OKAY   = 2'b00,
        AXI4_RESP_EXOKAY = 2'b01,
        AXI4_RESP_SLVERR = 2'b10,
        AXI4_RESP_DECERR = 2'b11
    } axi4_resp_t;

    typedef enum logic {
        ARB_ST_IDLE  = 1'b0,
        ARB_ST_ISSUE = 1'b1
    } axi4_arb_state_e;

    // Return the ID with its channel field overwritten and the tag kept.
    function automatic axi4_id_t axi4_id_set_channel(input axi4_id_t id,
                                                     input logic [AXI4_CH_W-1:0] ch);
        axi4_id_t r;
        r         = id;
        r.channel = ch;
        return r;
    endfunction

endpackage

// File: rtl/axi4_rr_pick.sv
// Combinational round-robin picker. It returns the first asserted request at
// or after ptr_i, wrapping modulo N, as both a one-hot grant and an index.
module axi4_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [2*N-1:0]   req2_s;
    logic [2*N-1:0]   rot_s;
    logic [IDX_W-1:0] off_s;
    logic [IDX_W:0]   sum_s;

    // Rotate the doubled request vector so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        req2_s  = {req_i, req_i};
        rot_s   = req2_s >> ptr_i;
        off_s   = {IDX_W{1'b0}};
        valid_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s   = IDX_W'(k);
                valid_o = 1'b1;
            end else begin
                off_s   = off_s;
                valid_o = valid_o;
            end
        end
        sum_s = {1'b0, ptr_i} + {1'b0, off_s};
        if (sum_s >= (IDX_W+1)'(N)) begin
            sum_s = sum_s - (IDX_W+1)'(N);
        end else begin
            sum_s = sum_s;
        end
        idx_o = sum_s[IDX_W-1:0];
        gnt_o = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = valid_o && (idx_o == IDX_W'(i));
        end
    end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Round-robin AXI4 read arbiter. It shares one AR/R master port among NREQ
// requesters, tags arid.channel with the winning requester, routes R beats
// back by rid.channel, and throttles each requester at MAX_OUTST open bursts.
// Optional build macro AXI4_RD_ARBITER_QOS_EN: when it is defined, only the
// eligible requesters with the highest s_arqos take part in arbitration.
module axi4_rd_arbiter
    import axi4_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int MAX_OUTST  = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NREQ-1:0]          s_arvalid,
    output logic [NREQ-1:0]          s_arready,
    input  logic [NREQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NREQ*8-1:0]        s_arlen,
    input  logic [NREQ*3-1:0]        s_arsize,
    input  logic [NREQ*2-1:0]        s_arburst,
    input  logic [NREQ*13-1:0]       s_arid,
    input  logic [NREQ*4-1:0]        s_arqos,
    output logic [NREQ-1:0]          s_rvalid,
    input  logic [NREQ-1:0]          s_rready,
    output logic [DATA_WIDTH-1:0]    s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rlast,
    output logic [12:0]              s_rid,
    output logic [ADDR_WIDTH-1:0]    m_araddr,
    output logic [7:0]               m_arlen,
    output logic [2:0]               m_arsize,
    output logic [1:0]               m_arburst,
    output logic [12:0]              m_arid,
    output logic [3:0]               m_arqos,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    input  logic [DATA_WIDTH-1:0]    m_rdata,
    input  logic [1:0]               m_rresp,
    input  logic                     m_rlast,
    input  logic [12:0]              m_rid,
    input  logic                     m_rvalid,
    output logic                     m_rready,
    output logic                     rid_err
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_OUTST);
    localparam logic [3:0]       NREQ_L   = 4'(NREQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    axi4_arb_state_e state_q;
    logic [IDX_W-1:0]      rr_q;
    logic [IDX_W-1:0]      win_q;
    logic                  m_arvalid_q;
    logic [ADDR_WIDTH-1:0] m_araddr_q;
    logic [7:0]            m_arlen_q;
    logic [2:0]            m_arsize_q;
    logic [1:0]            m_arburst_q;
    logic [12:0]           m_arid_q;
    logic [3:0]            m_arqos_q;
    logic                  rid_err_q;
    logic [CNT_W-1:0]      outst_q [NREQ];
    logic [CNT_W-1:0]      outst_d [NREQ];

    logic [NREQ-1:0]       elig_s;
    logic [NREQ-1:0]       cand_s;
    logic [NREQ-1:0]       pick_gnt_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  pick_vld_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [7:0]            sel_len_s;
    logic [2:0]            sel_size_s;
    logic [1:0]            sel_burst_s;
    logic [12:0]           sel_id_s;
    logic [3:0]            sel_qos_s;
    logic [AXI4_CH_W-1:0]  rid_ch_s;
    logic                  rid_ok_s;
    logic                  r_last_hs_s;
    logic                  ar_hs_s;

    assign rid_ch_s    = m_rid[AXI4_ID_W-1 -: AXI4_CH_W];
    assign rid_ok_s    = ({1'b0, rid_ch_s} < NREQ_L);
    assign r_last_hs_s = m_rvalid && m_rready && m_rlast;
    assign ar_hs_s     = (state_q == ARB_ST_ISSUE) && m_arready;

    // A requester is eligible when it is valid and below its outstanding limit. The optional QoS filter is applied on top.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i] = s_arvalid[i] && (outst_q[i] < MAX_L);
        end
`ifdef AXI4_RD_ARBITER_QOS_EN
        begin : qos_filter
            logic [3:0] max_qos_s;
            max_qos_s = 4'h0;
            for (int i = 0; i < NREQ; i++) begin
                if (elig_s[i] && (s_arqos[i*4 +: 4] > max_qos_s)) begin
                    max_qos_s = s_arqos[i*4 +: 4];
                end else begin
                    max_qos_s = max_qos_s;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                cand_s[i] = elig_s[i] && (s_arqos[i*4 +: 4] == max_qos_s);
            end
        end
`else
        cand_s = elig_s;
`endif
    end

    axi4_rr_pick #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (cand_s),
        .ptr_i   (rr_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_vld_s)
    );

    // Select the AR payload of the requester the picker chose.
    always_comb begin
        sel_addr_s  = {ADDR_WIDTH{1'b0}};
        sel_len_s   = 8'h00;
        sel_size_s  = 3'h0;
        sel_burst_s = 2'h0;
        sel_id_s    = 13'h0000;
        sel_qos_s   = 4'h0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx_s == IDX_W'(i)) begin
                sel_addr_s  = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len_s   = s_arlen[i*8 +: 8];
                sel_size_s  = s_arsize[i*3 +: 3];
                sel_burst_s = s_arburst[i*2 +: 2];
                sel_id_s    = s_arid[i*13 +: 13];
                sel_qos_s   = s_arqos[i*4 +: 4];
            end else begin
                sel_addr_s  = sel_addr_s;
            end
        end
    end

    // The idle arbiter accepts the winner in the same cycle. Nothing is accepted while an AR is being issued or during reset.
    always_comb begin
        if ((state_q == ARB_ST_IDLE) && aresetn) begin
            s_arready = pick_gnt_s;
        end else begin
            s_arready = {NREQ{1'b0}};
        end
    end

    // Arbitration FSM: capture the winner's payload in IDLE and hold it in ISSUE until the master accepts it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ARB_ST_IDLE;
            rr_q        <= {IDX_W{1'b0}};
            win_q       <= {IDX_W{1'b0}};
            m_arvalid_q <= 1'b0;
            m_araddr_q  <= {ADDR_WIDTH{1'b0}};
            m_arlen_q   <= 8'h00;
            m_arsize_q  <= 3'h0;
            m_arburst_q <= 2'h0;
            m_arid_q    <= 13'h0000;
            m_arqos_q   <= 4'h0;
        end else begin
            case (state_q)
                ARB_ST_IDLE: begin
                    if (pick_vld_s) begin
                        win_q       <= pick_idx_s;
                        m_araddr_q  <= sel_addr_s;
                        m_arlen_q   <= sel_len_s;
                        m_arsize_q  <= sel_size_s;
                        m_arburst_q <= sel_burst_s;
                        m_arid_q    <= axi4_id_set_channel(axi4_id_t'(sel_id_s),
                                                           AXI4_CH_W'(pick_idx_s));
                        m_arqos_q   <= sel_qos_s;
                        m_arvalid_q <= 1'b1;
                        state_q     <= ARB_ST_ISSUE;
                    end else begin
                        state_q     <= ARB_ST_IDLE;
                    end
                end
                ARB_ST_ISSUE: begin
                    if (m_arready) begin
                        m_arvalid_q <= 1'b0;
                        rr_q        <= (win_q == LAST_IDX) ? {IDX_W{1'b0}} : (win_q + 1'b1);
                        state_q     <= ARB_ST_IDLE;
                    end else begin
                        state_q     <= ARB_ST_ISSUE;
                    end
                end
                default: begin
                    m_arvalid_q <= 1'b0;
                    state_q     <= ARB_ST_IDLE;
                end
            endcase
        end
    end

    // Route R beats by rid.channel. Beats with an out-of-range channel are drained and not delivered to any requester.
    always_comb begin
        s_rvalid = {NREQ{1'b0}};
        if (rid_ok_s) begin
            m_rready = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (rid_ch_s == AXI4_CH_W'(i)) begin
                    s_rvalid[i] = m_rvalid;
                    m_rready    = s_rready[i];
                end else begin
                    s_rvalid[i] = 1'b0;
                end
            end
        end else begin
            m_rready = 1'b1;
        end
    end

    // Next value of each outstanding counter. An issue and a last beat in the same cycle cancel out; a decrement at zero saturates.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            case ({ar_hs_s && (win_q == IDX_W'(i)),
                   r_last_hs_s && rid_ok_s && (rid_ch_s == AXI4_CH_W'(i))})
                2'b10:   outst_d[i] = outst_q[i] + 1'b1;
                2'b01:   outst_d[i] = (outst_q[i] != {CNT_W{1'b0}}) ? (outst_q[i] - 1'b1)
                                                                    : outst_q[i];
                default: outst_d[i] = outst_q[i];
            endcase
        end
    end

    // Outstanding-burst counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NREQ; i++) begin
                outst_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    // Sticky flag for a beat carrying an unroutable rid. Only reset clears it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rid_err_q <= 1'b0;
        end else if (m_rvalid && !rid_ok_s) begin
            rid_err_q <= 1'b1;
        end else begin
            rid_err_q <= rid_err_q;
        end
    end

    assign m_arvalid = m_arvalid_q;
    assign m_araddr  = m_araddr_q;
    assign m_arlen   = m_arlen_q;
    assign m_arsize  = m_arsize_q;
    assign m_arburst = m_arburst_q;
    assign m_arid    = m_arid_q;
    assign m_arqos   = m_arqos_q;
    assign rid_err   = rid_err_q;
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign s_rid     = m_rid;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed testbench for axi4_rd_arbiter (NREQ=4, MAX_OUTST=4).
// Inputs change on the falling edge. Outputs are sampled 1 ns later, away from the rising edge.
module tb_axi4_rd_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 256;

    logic              aclk;
    logic              aresetn;
    logic [NREQ-1:0]   s_arvalid;
    logic [NREQ-1:0]   s_arready;
    logic [NREQ*AW-1:0] s_araddr;
    logic [NREQ*8-1:0] s_arlen;
    logic [NREQ*3-1:0] s_arsize;
    logic [NREQ*2-1:0] s_arburst;
    logic [NREQ*13-1:0] s_arid;
    logic [NREQ*4-1:0] s_arqos;
    logic [NREQ-1:0]   s_rvalid;
    logic [NREQ-1:0]   s_rready;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic [12:0]       s_rid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic [12:0]       m_arid;
    logic [3:0]        m_arqos;
    logic              m_arvalid;
    logic              m_arready;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic [12:0]       m_rid;
    logic              m_rvalid;
    logic              m_rready;
    logic              rid_err;

    int n_cmp = 0;
    int n_err = 0;

    axi4_rd_arbiter #(
        .NREQ       (NREQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_OUTST  (4)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arid    (s_arid),
        .s_arqos   (s_arqos),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rid     (s_rid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arid    (m_arid),
        .m_arqos   (m_arqos),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rid     (m_rid),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .rid_err   (rid_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Count one comparison and report it if it does not match.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load the AR payload of requester i. The valid bit is driven separately.
    task automatic set_req(input int i, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] ch, input logic [9:0] tag, input logic [3:0] qos);
        s_araddr[i*AW +: AW] = addr;
        s_arlen[i*8 +: 8]    = len;
        s_arsize[i*3 +: 3]   = 3'd5;
        s_arburst[i*2 +: 2]  = 2'b01;
        s_arid[i*13 +: 13]   = {ch, tag};
        s_arqos[i*4 +: 4]    = qos;
    endtask

    // Assert reset, check the reset state, and release reset on a falling edge.
    task automatic do_reset();
        @(negedge aclk);
        aresetn   = 1'b0;
        s_arvalid = 4'h0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        s_rready  = 4'h0;
        #1;
        check_eq("rst_m_arvalid", {63'd0, m_arvalid}, 64'd0);
        check_eq("rst_s_arready", {60'd0, s_arready}, 64'd0);
        check_eq("rst_rid_err",   {63'd0, rid_err},   64'd0);
        check_eq("rst_m_araddr",  {32'd0, m_araddr},  64'd0);
        check_eq("rst_m_arid",    {51'd0, m_arid},    64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        aresetn   = 1'b0;
        s_arvalid = 4'h0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_arid    = '0;
        s_arqos   = '0;
        s_rready  = 4'h0;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        m_rid     = 13'h0000;
        m_rvalid  = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h0, 8'h0, 3'd0, 10'h0, 4'h0);

        // Basic grant: requester 2 alone, with a bogus incoming channel of 7.
        do_reset();
        set_req(2, 32'h0000_1000, 8'd3, 3'd7, 10'h055, 4'h1);
        s_arvalid = 4'b0100;
        #1 check_eq("basic_arready", {60'd0, s_arready}, 64'h4);
        @(posedge aclk); #1;
        check_eq("basic_m_arvalid", {63'd0, m_arvalid}, 64'd1);
        check_eq("basic_m_arid",    {51'd0, m_arid},    {51'd0, 3'd2, 10'h055});
        check_eq("basic_m_araddr",  {32'd0, m_araddr},  64'h1000);
        check_eq("basic_m_arlen",   {56'd0, m_arlen},   64'd3);
        check_eq("basic_issue_rdy", {60'd0, s_arready}, 64'd0);
        @(negedge aclk);
        s_arvalid = 4'b0000;
        m_arready = 1'b1;
        #1 check_eq("basic_hold", {63'd0, m_arvalid}, 64'd1);
        @(posedge aclk); #1;
        check_eq("basic_accepted", {63'd0, m_arvalid}, 64'd0);
        @(negedge aclk);
        m_rvalid = 1'b1;
        m_rid    = {3'd2, 10'h055};
        s_rready = 4'b0000;
        #1 check_eq("basic_r_bp", {63'd0, m_rready}, 64'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge aclk);
            m_rdata  = DW'(64'h1234_0000 + 64'(b));
            m_rlast  = (b == 3);
            s_rready = 4'b0100;
            #1;
            check_eq("basic_r_valid", {60'd0, s_rvalid}, 64'h4);
            check_eq("basic_r_ready", {63'd0, m_rready}, 64'd1);
            check_eq("basic_r_data",  s_rdata[63:0],     64'h1234_0000 + 64'(b));
        end
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;

        // Fairness: all four requesters hold AR valid continuously.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h100 * i, 8'd0, 3'd0, 10'(i), 4'h0);
        s_arvalid = 4'hF;
        m_arready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            exp_gnt = (n % 2 == 0) ? 4'(1 << ((n / 2) % 4)) : 4'h0;
            #1 check_eq($sformatf("fair_%0d", n), {60'd0, s_arready}, {60'd0, exp_gnt});
            @(negedge aclk);
        end
        s_arvalid = 4'h0;

        // Throttle: requester 1 fills its four slots, then requester 3 still wins.
        do_reset();
        s_arvalid = 4'b0010;
        m_arready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            exp_gnt = (n % 2 == 0) ? 4'b0010 : 4'b0000;
            #1 check_eq($sformatf("thr_fill_%0d", n), {60'd0, s_arready}, {60'd0, exp_gnt});
            @(negedge aclk);
        end
        s_arvalid = 4'b1010;
        #1 check_eq("thr_req3", {60'd0, s_arready}, 64'h8);
        @(negedge aclk);
        s_arvalid = 4'b0010;
        #1 check_eq("thr_issue", {60'd0, s_arready}, 64'h0);
        @(negedge aclk);
        #1;
        check_eq("thr_blocked",   {60'd0, s_arready}, 64'h0);
        check_eq("thr_no_arvld",  {63'd0, m_arvalid}, 64'd0);
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        m_rid    = {3'd1, 10'h000};
        s_rready = 4'b0010;
        #1 check_eq("thr_r_route", {60'd0, s_rvalid}, 64'h2);
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1 check_eq("thr_reenable", {60'd0, s_arready}, 64'h2);
        @(negedge aclk);
        s_arvalid = 4'h0;

        // Backpressure: master holds off arready for 10 cycles.
        do_reset();
        set_req(0, 32'hABCD_0000, 8'd7, 3'd0, 10'h3A, 4'h0);
        m_arready = 1'b0;
        s_arvalid = 4'b0001;
        #1 check_eq("bp_grant", {60'd0, s_arready}, 64'h1);
        @(negedge aclk);
        s_arvalid = 4'hF;
        for (int n = 0; n < 10; n++) begin
            #1;
            check_eq("bp_arvalid", {63'd0, m_arvalid}, 64'd1);
            check_eq("bp_araddr",  {32'd0, m_araddr},  64'hABCD_0000);
            check_eq("bp_arready", {60'd0, s_arready}, 64'h0);
            @(negedge aclk);
        end
        m_arready = 1'b1;
        @(negedge aclk);
        #1 check_eq("bp_resume", {60'd0, s_arready}, 64'h2);
        @(negedge aclk);
        s_arvalid = 4'h0;

        // Bad id: channel 5 is out of range for four requesters.
        @(negedge aclk);
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        m_rid    = {3'd5, 10'h001};
        s_rready = 4'h0;
        #1;
        check_eq("bad_m_rready", {63'd0, m_rready}, 64'd1);
        check_eq("bad_s_rvalid", {60'd0, s_rvalid}, 64'h0);
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1 check_eq("bad_rid_err", {63'd0, rid_err}, 64'd1);
        repeat (3) @(negedge aclk);
        #1 check_eq("bad_rid_sticky", {63'd0, rid_err}, 64'd1);
        do_reset();
        // A last beat to an idle requester must saturate at zero and raise no error.
        @(negedge aclk);
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        m_rid    = {3'd0, 10'h000};
        s_rready = 4'b0001;
        @(negedge aclk);
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        s_arvalid = 4'b0001;
        #1;
        check_eq("sat_rid_err", {63'd0, rid_err},   64'd0);
        check_eq("sat_grant",   {60'd0, s_arready}, 64'h1);
        @(negedge aclk);
        s_arvalid = 4'h0;

        // QoS: requester 0 has qos 2 and requester 3 has qos 9.
        do_reset();
        set_req(0, 32'h0000_0A00, 8'd0, 3'd0, 10'h0, 4'd2);
        set_req(3, 32'h0000_3A00, 8'd0, 3'd0, 10'h0, 4'd9);
        m_arready = 1'b1;
        s_arvalid = 4'b1001;
`ifdef AXI4_RD_ARBITER_QOS_EN
        #1 check_eq("qos_first", {60'd0, s_arready}, 64'h8);
        @(posedge aclk); #1;
        check_eq("qos_first_qos", {60'd0, m_arqos}, 64'd9);
        @(negedge aclk);
        s_arvalid = 4'b0001;
        @(negedge aclk);
        #1 check_eq("qos_second", {60'd0, s_arready}, 64'h1);
        @(posedge aclk); #1;
        check_eq("qos_second_qos", {60'd0, m_arqos}, 64'd2);
`else
        #1 check_eq("rr_first", {60'd0, s_arready}, 64'h1);
        @(posedge aclk); #1;
        check_eq("rr_first_qos", {60'd0, m_arqos}, 64'd2);
        @(negedge aclk);
        s_arvalid = 4'b1000;
        @(negedge aclk);
        #1 check_eq("rr_second", {60'd0, s_arready}, 64'h8);
        @(posedge aclk); #1;
        check_eq("rr_second_qos", {60'd0, m_arqos}, 64'd9);
`endif
        @(negedge aclk);
        s_arvalid = 4'h0;
        repeat (2) @(negedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
